satd_vertical_acc: RTL

//  Consumer of the horizontal Hadamard rows (hth_0..hth_7) that the block datapath produces.

---
 rtl/satd_vertical_acc_if.sv | 30 +++
 rtl/satd_vertical_acc.sv | 121 ++++++++++++
 2 files changed

// File: rtl/satd_vertical_acc_if.sv
// Row-input / SATD-output handshake bundle for satd_vertical_acc.
// The row source drives the master side; the accumulator is the slave.
interface satd_vertical_acc_if #(
  parameter int IN_W   = 16,
  parameter int SATD_W = IN_W + 9
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] hth_0;
  logic signed [IN_W-1:0] hth_1;
  logic signed [IN_W-1:0] hth_2;
  logic signed [IN_W-1:0] hth_3;
  logic signed [IN_W-1:0] hth_4;
  logic signed [IN_W-1:0] hth_5;
  logic signed [IN_W-1:0] hth_6;
  logic signed [IN_W-1:0] hth_7;
  logic                   out_valid;
  logic                   out_ready;
  logic [SATD_W-1:0]      satd;

  modport master (
    output in_valid, hth_0, hth_1, hth_2, hth_3, hth_4, hth_5, hth_6, hth_7, out_ready,
    input  in_ready, out_valid, satd
  );

  modport slave (
    input  in_valid, hth_0, hth_1, hth_2, hth_3, hth_4, hth_5, hth_6, hth_7, out_ready,
    output in_ready, out_valid, satd
  );
endinterface

// File: rtl/satd_vertical_acc.sv
// Buffers 8 horizontal-HT rows, applies an 8-point vertical Hadamard per column and
// accumulates absolute coefficients over HEIGHT/8 stacked 8x8 sub-blocks into one raw SATD.
module satd_vertical_acc #(
  parameter int IN_W   = 16,
  parameter int HEIGHT = 16,
  parameter int SATD_W = IN_W + 9
) (
  input  logic               clk,
  input  logic               rst,
  satd_vertical_acc_if.slave bus
);

  localparam int W1    = IN_W + 1;
  localparam int W2    = IN_W + 2;
  localparam int W3    = IN_W + 3;
  localparam int SUM_W = W3 + 3;
  localparam int NBLK  = HEIGHT / 8;
  localparam int BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, DONE} state_t;

  state_t                       state_q;
  logic [2:0]                   row_cnt_q;
  logic [2:0]                   col_cnt_q;
  logic [BLK_W-1:0]             blk_cnt_q;
  logic [SATD_W-1:0]            acc_q;
  logic [SATD_W-1:0]            acc_d;
  logic [SATD_W-1:0]            satd_q;
  logic                         out_valid_q;
  logic [7:0][7:0][IN_W-1:0]    rowbuf_q;

  logic signed [IN_W-1:0]       x   [8];
  logic signed [W1-1:0]         s1  [8];
  logic signed [W2-1:0]         s2  [8];
  logic signed [W3-1:0]         s3  [8];
  logic [W3-1:0]                mag [8];
  logic [SUM_W-1:0]             col_sum;

  assign bus.in_ready  = (state_q == LOAD) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.satd      = satd_q;

  // Butterfly strides 4, 2, 1; each stage widens by one bit so nothing can wrap.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      x[i] = signed'(rowbuf_q[i][col_cnt_q]);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      s1[k]     = W1'(x[k]) + W1'(x[k+4]);
      s1[k+4]   = W1'(x[k]) - W1'(x[k+4]);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      s2[(k/2)*4 + (k%2)]     = W2'(s1[(k/2)*4 + (k%2)]) + W2'(s1[(k/2)*4 + (k%2) + 2]);
      s2[(k/2)*4 + (k%2) + 2] = W2'(s1[(k/2)*4 + (k%2)]) - W2'(s1[(k/2)*4 + (k%2) + 2]);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      s3[2*k]     = W3'(s2[2*k]) + W3'(s2[2*k+1]);
      s3[2*k+1]   = W3'(s2[2*k]) - W3'(s2[2*k+1]);
    end
    col_sum = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      // Negating the most negative value wraps to the same bit pattern, which read
      // unsigned is exactly its magnitude.
      mag[i]  = s3[i][W3-1] ? $unsigned(-s3[i]) : $unsigned(s3[i]);
      col_sum = col_sum + SUM_W'(mag[i]);
    end
    acc_d = acc_q + SATD_W'(col_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      blk_cnt_q   <= '0;
      acc_q       <= '0;
      satd_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (bus.in_valid) begin
            rowbuf_q[row_cnt_q] <= {bus.hth_7, bus.hth_6, bus.hth_5, bus.hth_4,
                                    bus.hth_3, bus.hth_2, bus.hth_1, bus.hth_0};
            if (row_cnt_q == 3'd7) begin
              row_cnt_q <= '0;
              col_cnt_q <= '0;
              state_q   <= COMPUTE;
            end else begin
              row_cnt_q <= row_cnt_q + 3'd1;
            end
          end
        end
        COMPUTE: begin
          acc_q     <= acc_d;
          col_cnt_q <= col_cnt_q + 3'd1;
          if (col_cnt_q == 3'd7) begin
            if (blk_cnt_q == BLK_W'(NBLK - 1)) begin
              satd_q      <= acc_d;
              out_valid_q <= 1'b1;
              blk_cnt_q   <= '0;
              state_q     <= DONE;
            end else begin
              blk_cnt_q <= blk_cnt_q + BLK_W'(1);
              state_q   <= LOAD;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            state_q     <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule
